sccb_responder: RTL and testbench
=================================

SCCB_RESPONDER -- requirements
Module: sccb_responder

Interface
REQ-001 The block SHALL have parameter c_id, default 7'h21, meaning the 7-bit slave ID it answers to.
REQ-002 The block SHALL have parameter c_pid, default 8'h76, meaning the read-only value of register 0x0A.
REQ-003 The block SHALL have parameter c_ver, default 8'h73, meaning the read-only value of register 0x0B.
REQ-004 The block SHALL have port clk, input, 1 bit: the system clock, 100 MHz.
REQ-005 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL have port sio_c, input, 1 bit: the SCCB clock from the master, at most 400 kHz.
REQ-007 The block SHALL have port sio_d_i, input, 1 bit: the SCCB data line as sampled at the pad.
REQ-008 The block SHALL have port sio_d_oe, output, 1 bit: when 1, the pad drives SIO_D low; when 0, the pad releases SIO_D.
REQ-009 The block SHALL have port wr_pulse, output, 1 bit: a one-clk strobe marking a completed register write.
REQ-010 The block SHALL have port wr_addr, output, 8 bits: the address of the last write.
REQ-011 The block SHALL have port wr_data, output, 8 bits: the data of the last write.
REQ-012 The block SHALL have port soft_rst, output, 1 bit: a one-clk strobe on a COM7 software reset.
REQ-013 The block SHALL have port busy, output, 1 bit: 1 from START to STOP while a transaction is in progress.
REQ-014 The block SHALL have port rd_addr, input, 8 bits: the local inspection address.
REQ-015 The block SHALL have port rd_data, output, 8 bits: the register-bank content at rd_addr, combinational.

Function
REQ-016 sio_c and sio_d_i SHALL each pass through a 2-FF synchronizer; all edge detection SHALL use the synchronized values.
REQ-017 START SHALL be detected when SIO_D falls while SIO_C is high; STOP SHALL be detected when SIO_D rises while SIO_C is high.
REQ-018 Incoming bits SHALL be sampled on the SIO_C rising edge, MSB first; sio_d_oe SHALL change only after an SIO_C falling edge.
REQ-019 The FSM states SHALL be IDLE, ID, ID_ACK, ADDR, ADDR_ACK, DATA, DATA_ACK, RD_DATA, RD_NA and IGNORE.
REQ-020 In IDLE, a START SHALL move the FSM to ID and clear the bit counter.
REQ-021 In ID, after 8 bits: if the top 7 bits equal c_id, the FSM SHALL go to ID_ACK; otherwise it SHALL go to IGNORE.
REQ-022 In each *_ACK state, sio_d_oe SHALL be 1 for the 9th SIO_C period.
REQ-023 After ID_ACK with the R/W bit = 0, the FSM SHALL go to ADDR; with R/W = 1, it SHALL go to RD_DATA.
REQ-024 ADDR SHALL latch an 8-bit sub-address register; the FSM SHALL then go through ADDR_ACK to DATA.
REQ-025 DATA SHALL take 8 bits; the bank write, wr_addr, wr_data and wr_pulse SHALL occur in the clk cycle after the synchronized rising edge that samples data bit 0, i.e. within 4 clk of the pin edge.
REQ-026 After DATA, the FSM SHALL pass through DATA_ACK and then wait for STOP.
REQ-027 The sub-address SHALL NOT auto-increment.
REQ-028 In RD_DATA, the block SHALL drive bank[sub-address] MSB first: sio_d_oe = 1 when the bit is 0.
REQ-029 In RD_NA, the block SHALL release the line and then wait for STOP.
REQ-030 The bank SHALL hold 256x8 registers, all reset to 0x00 except 0x0A = c_pid and 0x0B = c_ver.
REQ-031 Writes to 0x0A and 0x0B SHALL be acknowledged, SHALL leave the bank unchanged, and SHALL NOT assert wr_pulse.
REQ-032 A write of data with bit 7 = 1 to address 0x12 SHALL restore the whole bank to its reset values in one cycle, assert soft_rst and wr_pulse, and leave 0x12 reading 0x00.
REQ-033 A STOP in any state SHALL return the FSM to IDLE and release sio_d_oe; a partial byte SHALL be discarded with no write.
REQ-034 A repeated START in any state SHALL restart at ID; the sub-address SHALL be kept.
REQ-035 IGNORE SHALL never assert sio_d_oe and SHALL be left only on STOP or START.
REQ-036 If REQ-033/REQ-034 coincide with a sampling edge in the same cycle, START/STOP SHALL have priority.

Reset
REQ-037 While rst_n = 0, the block SHALL immediately force: sio_d_oe = 0, wr_pulse = 0, soft_rst = 0, busy = 0, wr_addr = 0x00, wr_data = 0x00, sub-address = 0x00, FSM = IDLE, bank = reset values, synchronizers = 1.
REQ-038 A reset asserted mid-transaction SHALL release the bus at once; the block SHALL then ignore bus traffic until the next START.

Configuration
REQ-039 With macro SCCB_READ_EN defined, read transactions SHALL operate per REQ-023, REQ-028 and REQ-029.
REQ-040 Without SCCB_READ_EN, an ID with R/W = 1 SHALL go to IGNORE with no ACK, and the RD_DATA/RD_NA logic SHALL be absent; rd_data SHALL remain.

Verification
REQ-041 Write 0x42, 0x40, 0xF0 at 100 kHz, then STOP -> three ACKs, wr_pulse once with wr_addr = 0x40 and wr_data = 0xF0, and rd_data@0x40 = 0xF0.
REQ-042 ID 0x44 (mismatch), then two bytes -> sio_d_oe stays 0 throughout, no wr_pulse, busy = 1 until STOP.
REQ-043 Write 0x12 = 0x80 after writing 0x40 = 0xF0 -> soft_rst pulse, 0x40 reads 0x00, 0x0A reads 0x76.
REQ-044 (SCCB_READ_EN) Write ID 0x42 and address 0x0B, STOP, then ID 0x43 -> bus carries 0x73, NA released, no wr_pulse.
REQ-045 STOP after 5 data bits, and separately a repeated START after the address byte -> no write, FSM in IDLE/ID respectively, bus released.
REQ-046 Pulse rst_n low during DATA_ACK -> sio_d_oe = 0 within the same cycle, and 0x0A reads 0x76 after release.

Source files
------------

// File: rtl/sccb_responder_if.sv
// SCCB pad-level bus bundle: master clock, sampled data line and the slave's open-drain pull-down enable.
`timescale 1ns/1ps

interface sccb_responder_if;
    logic sio_c;
    logic sio_d_i;
    logic sio_d_oe;

    modport master (output sio_c, output sio_d_i, input sio_d_oe);
    modport slave  (input sio_c, input sio_d_i, output sio_d_oe);
endinterface

// File: rtl/sccb_responder.sv
// SCCB slave with a 256x8 register bank, read-only ID registers at 0x0A/0x0B and a COM7 (0x12) soft reset.
// Define SCCB_READ_EN to build in read transactions (RD_DATA/RD_NA); by default reads are ignored without ACK.
`timescale 1ns/1ps

module sccb_responder #(
    parameter logic [6:0] c_id  = 7'h21,
    parameter logic [7:0] c_pid = 8'h76,
    parameter logic [7:0] c_ver = 8'h73
) (
    input  logic             clk,
    input  logic             rst_n,
    sccb_responder_if.slave  bus,
    output logic             wr_pulse,
    output logic [7:0]       wr_addr,
    output logic [7:0]       wr_data,
    output logic             soft_rst,
    output logic             busy,
    input  logic [7:0]       rd_addr,
    output logic [7:0]       rd_data
);

    typedef enum logic [3:0] {
        IDLE, ID, ID_ACK, ADDR, ADDR_ACK, DATA, DATA_ACK, RD_DATA, RD_NA, IGNORE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        c_sync, d_sync;
    logic              c_q, d_q;
    logic              c_s, d_s;
    logic              scl_rise, scl_fall, start, stop;
    logic [2:0]        bit_q, bit_d;
    logic [6:0]        sh_q, sh_d;
    logic              oe_q, oe_d;
    logic [7:0]        sub_q, sub_d;
    logic [7:0]        rx_byte;
    logic              do_write;
    logic              read_only;
    logic [255:0][7:0] bank;
`ifdef SCCB_READ_EN
    logic              rw_q, rw_d;
`endif

    // The extra c_q/d_q stage holds the previous synchronized value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
            c_q    <= 1'b1;
            d_q    <= 1'b1;
        end else begin
            c_sync <= {c_sync[0], bus.sio_c};
            d_sync <= {d_sync[0], bus.sio_d_i};
            c_q    <= c_sync[1];
            d_q    <= d_sync[1];
        end
    end

    assign c_s      = c_sync[1];
    assign d_s      = d_sync[1];
    assign scl_rise = c_s & ~c_q;
    assign scl_fall = ~c_s & c_q;
    assign start    = c_s & c_q & d_q & ~d_s;
    assign stop     = c_s & c_q & ~d_q & d_s;
    assign rx_byte  = {sh_q, d_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bit_q   <= 3'd0;
            sh_q    <= 7'd0;
            oe_q    <= 1'b0;
            sub_q   <= 8'h00;
`ifdef SCCB_READ_EN
            rw_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            oe_q    <= oe_d;
            sub_q   <= sub_d;
`ifdef SCCB_READ_EN
            rw_q    <= rw_d;
`endif
        end
    end

    // Bus conditions are checked before any sampling edge so START/STOP always win.
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        oe_d     = oe_q;
        sub_d    = sub_q;
        do_write = 1'b0;
`ifdef SCCB_READ_EN
        rw_d     = rw_q;
`endif
        if (stop) begin
            state_d = IDLE;
            oe_d    = 1'b0;
        end else if (start) begin
            state_d = ID;
            bit_d   = 3'd0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                ID, ADDR, DATA: begin
                    if (scl_rise) begin
                        sh_d  = rx_byte[6:0];
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            if (state_q == ID) begin
                                if (rx_byte[7:1] == c_id) begin
`ifdef SCCB_READ_EN
                                    state_d = ID_ACK;
                                    rw_d    = rx_byte[0];
`else
                                    state_d = rx_byte[0] ? IGNORE : ID_ACK;
`endif
                                end else begin
                                    state_d = IGNORE;
                                end
                            end else if (state_q == ADDR) begin
                                sub_d   = rx_byte;
                                state_d = ADDR_ACK;
                            end else begin
                                do_write = 1'b1;
                                state_d  = DATA_ACK;
                            end
                        end
                    end
                end
                // First falling edge starts the pull-down, the one after the 9th rising edge ends it.
                ID_ACK, ADDR_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d  = 1'b0;
                            bit_d = 3'd0;
                            if (state_q == ID_ACK) begin
`ifdef SCCB_READ_EN
                                if (rw_q) begin
                                    state_d = RD_DATA;
                                    sh_d    = bank[sub_q][6:0];
                                    oe_d    = ~bank[sub_q][7];
                                end else begin
                                    state_d = ADDR;
                                end
`else
                                state_d = ADDR;
`endif
                            end else if (state_q == ADDR_ACK) begin
                                state_d = DATA;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
`ifdef SCCB_READ_EN
                RD_DATA: begin
                    if (scl_rise) begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = RD_NA;
                        end
                    end else if (scl_fall) begin
                        oe_d = ~sh_q[6];
                        sh_d = {sh_q[5:0], 1'b0};
                    end
                end
                RD_NA: begin
                    if (scl_fall) begin
                        oe_d = 1'b0;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign read_only = (sub_q == 8'h0A) || (sub_q == 8'h0B);

    // Writes to the ID registers are acknowledged on the bus but have no effect here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank     <= '0;
            bank[10] <= c_pid;
            bank[11] <= c_ver;
            wr_pulse <= 1'b0;
            soft_rst <= 1'b0;
            wr_addr  <= 8'h00;
            wr_data  <= 8'h00;
        end else begin
            wr_pulse <= 1'b0;
            soft_rst <= 1'b0;
            if (do_write && !read_only) begin
                wr_pulse <= 1'b1;
                wr_addr  <= sub_q;
                wr_data  <= rx_byte;
                if (sub_q == 8'h12 && rx_byte[7]) begin
                    soft_rst <= 1'b1;
                    bank     <= '0;
                    bank[10] <= c_pid;
                    bank[11] <= c_ver;
                end else begin
                    bank[sub_q] <= rx_byte;
                end
            end
        end
    end

    assign bus.sio_d_oe = oe_q;
    assign busy         = (state_q != IDLE);
    assign rd_data      = bank[rd_addr];

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: bit-banged SCCB master on a wired-AND SIO_D line.
`timescale 1ns/1ps

module tb_sccb_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] rd_addr = 8'h00;
    logic       wr_pulse, soft_rst, busy;
    logic [7:0] wr_addr, wr_data, rd_data;

    int         tests_run = 0;
    int         tests_failed = 0;
    int         wr_count = 0;
    int         soft_count = 0;
    logic [7:0] last_wr_addr = 8'h00;
    logic [7:0] last_wr_data = 8'h00;
    logic       oe_seen = 1'b0;
    int         q = 200;

    sccb_responder_if bus ();

    assign bus.sio_c   = m_scl;
    assign bus.sio_d_i = m_sda & ~bus.sio_d_oe;

    sccb_responder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .soft_rst (soft_rst),
        .busy     (busy),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_pulse === 1'b1) begin
            wr_count++;
            last_wr_addr = wr_addr;
            last_wr_data = wr_data;
        end
        if (soft_rst === 1'b1) soft_count++;
        if (bus.sio_d_oe === 1'b1) oe_seen = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_reg(input string tag, input logic [7:0] a, input logic [7:0] expected);
        rd_addr = a;
        #1;
        checkOutput(tag, {24'h0, rd_data}, {24'h0, expected});
    endtask

    task automatic sccb_start();
        m_sda = 1'b1;
        #(q);
        m_scl = 1'b1;
        #(q);
        m_sda = 1'b0;
        #(q);
        m_scl = 1'b0;
        #(q);
    endtask

    task automatic sccb_stop();
        m_sda = 1'b0;
        #(q);
        m_scl = 1'b1;
        #(q);
        m_sda = 1'b1;
        #(q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            m_sda = b[i];
            #(q);
            m_scl = 1'b1;
            #(2 * q);
            m_scl = 1'b0;
            #(q);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        m_sda = 1'b1;
        #(q);
        m_scl = 1'b1;
        #(q);
        ack = (bus.sio_d_i == 1'b0);
        #(q);
        m_scl = 1'b0;
        #(q);
    endtask

    task automatic read_byte(output logic [7:0] b, output logic na_oe);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            #(q);
            m_scl = 1'b1;
            #(q);
            b[i] = bus.sio_d_i;
            #(q);
            m_scl = 1'b0;
            #(q);
        end
        #(q);
        m_scl = 1'b1;
        #(q);
        na_oe = bus.sio_d_oe;
        #(q);
        m_scl = 1'b0;
        #(q);
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d, output logic [2:0] acks);
        logic k;
        sccb_start();
        send_byte(8'h42, k); acks[2] = k;
        send_byte(a, k);     acks[1] = k;
        send_byte(d, k);     acks[0] = k;
        sccb_stop();
    endtask

    task automatic applyStimulus();
        logic       ack;
        logic [2:0] acks;
        logic [7:0] rbyte;
        logic       na_oe;
        int         wc;

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rst_oe", {31'h0, bus.sio_d_oe}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_wr_addr", {24'h0, wr_addr}, 32'h0);
        checkOutput("rst_wr_data", {24'h0, wr_data}, 32'h0);
        check_reg("rst_pid", 8'h0A, 8'h76);
        check_reg("rst_ver", 8'h0B, 8'h73);
        check_reg("rst_r40", 8'h40, 8'h00);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Basic write at 100 kHz
        q = 2500;
        sccb_start();
        #1;
        checkOutput("w_busy", {31'h0, busy}, 32'h1);
        send_byte(8'h42, ack); acks[2] = ack;
        send_byte(8'h40, ack); acks[1] = ack;
        send_byte(8'hF0, ack); acks[0] = ack;
        sccb_stop();
        checkOutput("w_acks", {29'h0, acks}, 32'h7);
        checkOutput("w_count", wr_count, 32'd1);
        checkOutput("w_addr", {24'h0, last_wr_addr}, 32'h40);
        checkOutput("w_data", {24'h0, last_wr_data}, 32'hF0);
        check_reg("w_r40", 8'h40, 8'hF0);
        checkOutput("w_idle", {31'h0, busy}, 32'h0);
        q = 200;

        // ID mismatch
        oe_seen = 1'b0;
        sccb_start();
        send_byte(8'h44, ack); acks[2] = ack;
        send_byte(8'h40, ack); acks[1] = ack;
        send_byte(8'h11, ack); acks[0] = ack;
        checkOutput("mm_busy", {31'h0, busy}, 32'h1);
        sccb_stop();
        checkOutput("mm_acks", {29'h0, acks}, 32'h0);
        checkOutput("mm_oe_seen", {31'h0, oe_seen}, 32'h0);
        checkOutput("mm_count", wr_count, 32'd1);
        checkOutput("mm_idle", {31'h0, busy}, 32'h0);
        check_reg("mm_r40", 8'h40, 8'hF0);

        // Read-only registers are acknowledged and left untouched
        write_reg(8'h0A, 8'h11, acks);
        checkOutput("ro_acks", {29'h0, acks}, 32'h7);
        checkOutput("ro_count", wr_count, 32'd1);
        check_reg("ro_pid", 8'h0A, 8'h76);

        // Second data byte is not acknowledged and there is no auto-increment
        sccb_start();
        send_byte(8'h42, ack); acks[2] = ack;
        send_byte(8'h20, ack); acks[1] = ack;
        send_byte(8'h11, ack); acks[0] = ack;
        checkOutput("ai_acks", {29'h0, acks}, 32'h7);
        send_byte(8'h22, ack);
        checkOutput("ai_ack4", {31'h0, ack}, 32'h0);
        sccb_stop();
        checkOutput("ai_count", wr_count, 32'd2);
        check_reg("ai_r20", 8'h20, 8'h11);
        check_reg("ai_r21", 8'h21, 8'h00);

        // COM7 without bit 7 is a plain write, with bit 7 a soft reset
        write_reg(8'h12, 8'h05, acks);
        checkOutput("c7_plain_soft", soft_count, 32'd0);
        check_reg("c7_plain_r12", 8'h12, 8'h05);
        write_reg(8'h12, 8'h80, acks);
        checkOutput("sr_acks", {29'h0, acks}, 32'h7);
        checkOutput("sr_soft", soft_count, 32'd1);
        checkOutput("sr_count", wr_count, 32'd4);
        checkOutput("sr_addr", {24'h0, last_wr_addr}, 32'h12);
        check_reg("sr_r40", 8'h40, 8'h00);
        check_reg("sr_r12", 8'h12, 8'h00);
        check_reg("sr_r20", 8'h20, 8'h00);
        check_reg("sr_pid", 8'h0A, 8'h76);

        // Read of the version register (or refusal of reads)
        wc = wr_count;
        sccb_start();
        send_byte(8'h42, ack); acks[1] = ack;
        send_byte(8'h0B, ack); acks[0] = ack;
        sccb_stop();
        checkOutput("rd_setup_acks", {30'h0, acks[1:0]}, 32'h3);
        sccb_start();
        send_byte(8'h43, ack);
`ifdef SCCB_READ_EN
        checkOutput("rd_id_ack", {31'h0, ack}, 32'h1);
        read_byte(rbyte, na_oe);
        checkOutput("rd_byte", {24'h0, rbyte}, 32'h73);
        checkOutput("rd_na_oe", {31'h0, na_oe}, 32'h0);
`else
        checkOutput("rd_id_noack", {31'h0, ack}, 32'h0);
        oe_seen = 1'b0;
        read_byte(rbyte, na_oe);
        checkOutput("rd_off_byte", {24'h0, rbyte}, 32'hFF);
        checkOutput("rd_off_oe", {31'h0, oe_seen}, 32'h0);
`endif
        checkOutput("rd_busy", {31'h0, busy}, 32'h1);
        sccb_stop();
        checkOutput("rd_count", wr_count, wc);
        checkOutput("rd_idle", {31'h0, busy}, 32'h0);

        // STOP after 5 data bits discards the partial byte
        wc = wr_count;
        sccb_start();
        send_byte(8'h42, ack);
        send_byte(8'h30, ack);
        send_bits(8'hFF, 5);
        sccb_stop();
        checkOutput("ps_count", wr_count, wc);
        checkOutput("ps_idle", {31'h0, busy}, 32'h0);
        checkOutput("ps_oe", {31'h0, bus.sio_d_oe}, 32'h0);
        check_reg("ps_r30", 8'h30, 8'h00);

        // Repeated START after the address byte restarts at ID
        sccb_start();
        send_byte(8'h42, ack);
        send_byte(8'h31, ack);
        sccb_start();
        checkOutput("rs_busy", {31'h0, busy}, 32'h1);
        checkOutput("rs_oe", {31'h0, bus.sio_d_oe}, 32'h0);
        checkOutput("rs_count", wr_count, wc);
        send_byte(8'h42, ack);
        checkOutput("rs_id_ack", {31'h0, ack}, 32'h1);
        sccb_stop();
        check_reg("rs_r31", 8'h31, 8'h00);

        // Reset pulse during DATA_ACK
        sccb_start();
        send_byte(8'h42, ack);
        send_byte(8'h50, ack);
        send_bits(8'h5A, 8);
        m_sda = 1'b1;
        #(q);
        m_scl = 1'b1;
        #(q);
        checkOutput("ra_oe_before", {31'h0, bus.sio_d_oe}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("ra_oe_reset", {31'h0, bus.sio_d_oe}, 32'h0);
        #50;
        rst_n = 1'b1;
        #(q);
        m_scl = 1'b0;
        #(q);
        oe_seen = 1'b0;
        wc = wr_count;
        send_byte(8'h42, ack);
        checkOutput("ra_ignored_ack", {31'h0, ack}, 32'h0);
        checkOutput("ra_oe_seen", {31'h0, oe_seen}, 32'h0);
        checkOutput("ra_busy", {31'h0, busy}, 32'h0);
        sccb_stop();
        checkOutput("ra_count", wr_count, wc);
        check_reg("ra_pid", 8'h0A, 8'h76);
        check_reg("ra_r50", 8'h50, 8'h00);
    endtask

    initial begin
        applyStimulus();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
